corescore_reset_seq: RTL and testbench
======================================

Name: corescore_reset_seq

Overview:
- Parametrised reset sequencer for the system clock domain produced by the board PLL.
- Synchronises the PLL lock indicator and requires it to stay high for a programmable stable period.
- Releases NUM_RST reset channels one at a time, with a programmable gap between channels, then signals ready.
- On loss of lock it reasserts every channel and restarts the sequence. It extends the single-channel, fixed two-flop lock-to-reset stretcher with configurable depth, channel count and lock-loss handling.

Parameters:
- NUM_RST, 2: number of reset output channels (>=1).
- LOCK_SYNC, 2: synchroniser depth for i_locked (>=2).
- LOCK_STABLE, 16: cycles the synchronised lock must stay high before the first release (>=1).
- STAGE_DELAY, 4: cycles between successive channel releases (>=1).
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- i_clk  input  1  system clock; the single clock, all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_locked  input  1  PLL lock; asynchronous to i_clk.
- o_rst  output  NUM_RST  per-channel active-high reset, registered; bit 0 released first.
- o_ready  output  1  high once all channels are released, registered.
- o_loss_cnt  output  LOSS_CNT_W  lock-loss event count (see Optional Feature).

Behaviour:
- Reset: one clock, i_clk; i_rst is synchronous and active-high.
  - While i_rst is high: o_rst = all ones, o_ready = 0, o_loss_cnt = 0, synchroniser flops = 0, counters = 0, state = WAIT_LOCK.
  - i_rst high in any state aborts the sequence at that edge.
- Synchroniser: i_locked passes through LOCK_SYNC flops; lk denotes the last stage. No other logic samples i_locked.
- States:
  - WAIT_LOCK: o_rst all ones, o_ready 0, cnt = 0. If lk = 1 go to STABLE with cnt = 1.
  - STABLE: if lk = 0, go to WAIT_LOCK and clear cnt. Else if cnt = LOCK_STABLE, go to RELEASE, clear o_rst[0] at this edge and set stage = 0. Else increment cnt.
  - RELEASE: if lk = 0, treat as lock loss. Else a delay counter runs. Every STAGE_DELAY cycles, stage increments and o_rst[stage] clears. When bit NUM_RST-1 clears, go to RUN and set o_ready = 1 at the same edge. If NUM_RST = 1, go directly from STABLE to RUN; o_rst[0] and o_ready change at the same edge.
  - RUN: outputs hold. If lk = 0, treat as lock loss.
- Lock loss (lk = 0 in RELEASE or RUN):
  - At that edge: o_rst = all ones, o_ready = 0, counters cleared, state = WAIT_LOCK.
  - Lock loss in STABLE only restarts the count; o_rst is already all ones.
- Timing: let T0 be the first edge where lk = 1 (lk follows i_locked LOCK_SYNC edges later).
  - o_rst[k] falls at edge T0 + LOCK_STABLE + k*STAGE_DELAY.
  - o_ready rises with o_rst[NUM_RST-1].
  - Defaults: i_locked high before edge E1 gives T0 = E2, o_rst[0] falling at E18, o_rst[1] and o_ready at E22.
- Invariant: released channels are always a contiguous low-index prefix. o_rst[j] = 0 implies o_rst[i] = 0 for all i < j.
- A lk glitch shorter than the stable window delays release; it never produces a partial release.

Optional Feature:
- Macro: CORESCORE_RESET_SEQ_LOSS_CNT_EN.
- Defined: o_loss_cnt increments by 1 on each lock-loss event in RELEASE or RUN.
  - Saturates at all ones.
  - Cleared only by i_rst.
  - Lock loss in STABLE is not counted.
- Undefined: no counter logic is built; o_loss_cnt is tied to 0.

Test Plan:
- Defaults; i_rst high 3 cycles, i_locked = 0 -> o_rst = 2'b11 and o_ready = 0 indefinitely, o_loss_cnt = 0.
- Defaults; i_locked high before E1 -> o_rst[0] falls at E18, o_rst[1] and o_ready rise/fall at E22, nothing changes earlier.
- Defaults; i_locked pulses low 1 cycle when lk has been high 10 cycles -> window restarts; o_rst[0] falls 16 edges after lk returns high.
- Defaults with macro; lock lost in RUN -> next edge o_rst = 2'b11, o_ready = 0, o_loss_cnt = 1. Relock -> full sequence repeats. 256 losses with LOSS_CNT_W = 8 -> counter holds at 255.
- NUM_RST = 1 and NUM_RST = 4, STAGE_DELAY = 1 -> o_ready rises with the last release. With 4 channels, bits release on consecutive edges, lowest index first.
- i_rst asserted mid-RELEASE (o_rst = 2'b10) -> next edge o_rst = 2'b11, o_ready = 0, o_loss_cnt = 0, sequence restarts from synchroniser reset.

Source files
------------

// File: rtl/corescore_reset_seq.sv
// corescore_reset_seq: reset sequencer for the PLL-derived system clock domain.
//
// The PLL lock indicator is synchronised, must stay high for LOCK_STABLE cycles,
// then NUM_RST reset channels are released one at a time (bit 0 first), STAGE_DELAY
// cycles apart. o_ready rises together with the last release. Losing lock after the
// first release reasserts every channel and restarts the whole sequence.
//
// Optional feature: define CORESCORE_RESET_SEQ_LOSS_CNT_EN to build a saturating
// counter of lock-loss events (RELEASE or RUN only). Without it o_loss_cnt is 0.
//
// Ports:
//   i_clk       system clock, all logic on its rising edge
//   i_rst       synchronous active-high reset
//   i_locked    PLL lock, asynchronous to i_clk
//   o_rst       per-channel active-high reset, registered, bit 0 released first
//   o_ready     high once every channel is released, registered
//   o_loss_cnt  lock-loss event count (0 unless the optional feature is built)

module corescore_reset_seq #(
  parameter int unsigned NUM_RST     = 2,
  parameter int unsigned LOCK_SYNC   = 2,
  parameter int unsigned LOCK_STABLE = 16,
  parameter int unsigned STAGE_DELAY = 4,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_locked,
  output logic [NUM_RST-1:0]    o_rst,
  output logic                  o_ready,
  output logic [LOSS_CNT_W-1:0] o_loss_cnt
);

  // Counters only ever need to reach their limit minus one.
  localparam int unsigned CNT_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int unsigned DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int unsigned STG_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_RST - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [LOCK_SYNC-1:0] sync_q;
  logic                lk;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  logic [STG_W-1:0]    stage_nxt;
  logic [NUM_RST-1:0]  rst_q, rst_d;
  logic                ready_q, ready_d;
  logic                start_release;
  logic                loss_event;

  // Lock synchroniser; lk is the only view of i_locked used anywhere else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC-2:0], i_locked};
    end
  end

  assign lk        = sync_q[LOCK_SYNC-1];
  assign stage_nxt = stage_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      dly_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dly_d         = dly_q;
    stage_d       = stage_q;
    rst_d         = rst_q;
    ready_d       = ready_q;
    start_release = 1'b0;
    loss_event    = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        if (lk) begin
          // The edge that first sees lk already counts as one stable cycle.
          if (LOCK_STABLE == 1) begin
            start_release = 1'b1;
          end else begin
            state_d = StStable;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      StStable: begin
        if (!lk) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          start_release = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!lk) begin
          loss_event = 1'b1;
        end else if (dly_q == DLY_LAST) begin
          dly_d            = '0;
          stage_d          = stage_nxt;
          rst_d[stage_nxt] = 1'b0;
          if (stage_nxt == STG_LAST) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StRun: begin
        if (!lk) begin
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = StWaitLock;
      end
    endcase

    if (start_release) begin
      cnt_d    = '0;
      dly_d    = '0;
      stage_d  = '0;
      rst_d[0] = 1'b0;
      if (NUM_RST == 1) begin
        state_d = StRun;
        ready_d = 1'b1;
      end else begin
        state_d = StRelease;
      end
    end

    if (loss_event) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      dly_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;

`ifdef CORESCORE_RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  // Saturating; only i_rst clears it, a relock does not.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign o_loss_cnt = loss_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
  assign o_loss_cnt        = '0;
`endif

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Bench for corescore_reset_seq. Three instances share i_rst/i_locked:
//   cfg 0: defaults; cfg 1: 4 channels, 3-flop sync, short window, back-to-back
//   releases; cfg 2: single channel with a one-cycle window.
// The reference model only tracks how many consecutive edges the synchronised lock
// has been seen high; released channels and ready follow from that run length.

module tb_corescore_reset_seq;

  localparam int NCFG = 3;
  localparam int NR[NCFG] = '{2, 4, 1};
  localparam int SY[NCFG] = '{2, 3, 2};
  localparam int LS[NCFG] = '{16, 3, 1};
  localparam int SD[NCFG] = '{4, 1, 1};
  localparam int LW[NCFG] = '{8, 3, 2};

`ifdef CORESCORE_RESET_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk;
  logic       i_rst;
  logic       i_locked;
  logic [1:0] a_rst;
  logic       a_ready;
  logic [7:0] a_loss;
  logic [3:0] b_rst;
  logic       b_ready;
  logic [2:0] b_loss;
  logic [0:0] c_rst;
  logic       c_ready;
  logic [1:0] c_loss;

  int checks = 0;
  int errors = 0;

  corescore_reset_seq dut_a (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_locked   (i_locked),
    .o_rst      (a_rst),
    .o_ready    (a_ready),
    .o_loss_cnt (a_loss)
  );

  corescore_reset_seq #(
    .NUM_RST     (4),
    .LOCK_SYNC   (3),
    .LOCK_STABLE (3),
    .STAGE_DELAY (1),
    .LOSS_CNT_W  (3)
  ) dut_b (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_locked   (i_locked),
    .o_rst      (b_rst),
    .o_ready    (b_ready),
    .o_loss_cnt (b_loss)
  );

  corescore_reset_seq #(
    .NUM_RST     (1),
    .LOCK_SYNC   (2),
    .LOCK_STABLE (1),
    .STAGE_DELAY (1),
    .LOSS_CNT_W  (2)
  ) dut_c (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_locked   (i_locked),
    .o_rst      (c_rst),
    .o_ready    (c_ready),
    .o_loss_cnt (c_loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel k is released once the lock has been seen for LS + k*SD edges.
  function automatic logic [7:0] exp_rst(input int run, input int c);
    logic [7:0] m;
    int rel;
    rel = 0;
    for (int k = 0; k < NR[c]; k++) begin
      if (run >= LS[c] + k * SD[c]) rel++;
    end
    m = 8'hFF << rel;
    return m & ~(8'hFF << NR[c]);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] hist[NCFG];
  int         run[NCFG];
  int         loss[NCFG];
  bit         started = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (i_rst) begin
        hist[c] = '0;
        run[c]  = 0;
        loss[c] = 0;
      end else begin
        if (hist[c][SY[c]-1]) begin
          if (run[c] < 100000) run[c] = run[c] + 1;
        end else begin
          // A loss counts only once at least one channel had been released.
          if (LOSS_EN && run[c] >= LS[c] && loss[c] < (1 << LW[c]) - 1) loss[c] = loss[c] + 1;
          run[c] = 0;
        end
        hist[c] = {hist[c][6:0], i_locked};
      end
    end
    started = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] rst_v[NCFG];
  logic       rdy_v[NCFG];
  logic [7:0] loss_v[NCFG];

  assign rst_v[0]  = {6'b0, a_rst};
  assign rst_v[1]  = {4'b0, b_rst};
  assign rst_v[2]  = {7'b0, c_rst};
  assign rdy_v[0]  = a_ready;
  assign rdy_v[1]  = b_ready;
  assign rdy_v[2]  = c_ready;
  assign loss_v[0] = a_loss;
  assign loss_v[1] = {5'b0, b_loss};
  assign loss_v[2] = {6'b0, c_loss};

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < NCFG; c++) begin
        check($sformatf("model_rst%0d", c), 32'(rst_v[c]), 32'(exp_rst(run[c], c)));
        check($sformatf("model_ready%0d", c), 32'(rdy_v[c]),
              32'(run[c] >= LS[c] + (NR[c] - 1) * SD[c]));
        check($sformatf("model_loss%0d", c), 32'(loss_v[c]), 32'(loss[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int hold;
    i_rst    = 1'b1;
    i_locked = 1'b0;
    tick(3);
    check("reset_rst", 32'(a_rst), 32'h3);
    check("reset_ready", 32'(a_ready), 32'h0);
    check("reset_loss", 32'(a_loss), 32'h0);
    i_rst = 1'b0;
    tick(20);
    check("nolock_rst", 32'(a_rst), 32'h3);
    check("nolock_ready", 32'(a_ready), 32'h0);

    // Locked before E1: release at E18, last channel and ready at E22.
    i_rst = 1'b1;
    tick(1);
    i_rst    = 1'b0;
    i_locked = 1'b1;
    tick(17);
    check("e17_rst", 32'(a_rst), 32'h3);
    tick(1);
    check("e18_rst", 32'(a_rst), 32'h2);
    check("e18_ready", 32'(a_ready), 32'h0);
    tick(3);
    check("e21_rst", 32'(a_rst), 32'h2);
    check("e21_ready", 32'(a_ready), 32'h0);
    tick(1);
    check("e22_rst", 32'(a_rst), 32'h0);
    check("e22_ready", 32'(a_ready), 32'h1);

    // Lock lost in RUN: sampled at E31, seen by the sequencer at E33.
    tick(8);
    i_locked = 1'b0;
    tick(2);
    check("loss_e32_rst", 32'(a_rst), 32'h0);
    tick(1);
    check("loss_e33_rst", 32'(a_rst), 32'h3);
    check("loss_e33_ready", 32'(a_ready), 32'h0);
    check("loss_e33_cnt", 32'(a_loss), LOSS_EN ? 32'h1 : 32'h0);

    // One-cycle glitch after lk high 10 cycles: lk back high at E13, release at E29.
    i_rst = 1'b1;
    tick(1);
    i_rst    = 1'b0;
    i_locked = 1'b1;
    tick(10);
    i_locked = 1'b0;
    tick(1);
    i_locked = 1'b1;
    tick(17);
    check("glitch_e28_rst", 32'(a_rst), 32'h3);
    tick(1);
    check("glitch_e29_rst", 32'(a_rst), 32'h2);

    // i_rst mid-release, then the full sequence from synchroniser reset.
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    tick(19);
    check("midrel_rst", 32'(a_rst), 32'h2);
    i_rst = 1'b1;
    tick(1);
    check("midrel_abort_rst", 32'(a_rst), 32'h3);
    check("midrel_abort_ready", 32'(a_ready), 32'h0);
    check("midrel_abort_loss", 32'(a_loss), 32'h0);
    i_rst = 1'b0;
    tick(17);
    check("restart_e17_rst", 32'(a_rst), 32'h3);
    tick(1);
    check("restart_e18_rst", 32'(a_rst), 32'h2);

    // 256 losses from RUN: the 8-bit counter must hold at 255.
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      i_locked = 1'b1;
      tick(24);
      i_locked = 1'b0;
      tick(3);
    end
    check("sat_loss", 32'(a_loss), LOSS_EN ? 32'd255 : 32'd0);
    check("sat_rst", 32'(a_rst), 32'h3);

    // Random lock activity with occasional resets.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        i_locked = ~i_locked;
        hold     = $urandom_range(1, 40);
      end
      hold--;
      i_rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
